// File: rtl/dac_spi_pkg.sv
// rtl/dac_spi_pkg.sv - shared state encoding and DAC frame layout for the DAC SPI driver
package dac_spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        GAP   = 3'd3,
        LATCH = 3'd4
    } state_t;

    localparam int FRAME_BITS   = 16;
    localparam int HALF_PERIODS = 2 * FRAME_BITS;
    localparam int BIT_CH       = 15;
    localparam int BIT_BUF      = 14;
    localparam int BIT_GA_N     = 13;
    localparam int BIT_SHDN_N   = 12;
    localparam int DATA_MSB     = 11;

endpackage

// File: rtl/spi_tick_gen.sv
// rtl/spi_tick_gen.sv - one-cycle tick every CLK_DIV cycles while run is high
module spi_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV) + 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!run || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = run && (cnt == LAST);

endmodule

// File: rtl/dac_spi_driver.sv
// rtl/dac_spi_driver.sv - writes changed 12-bit setpoints to a dual-channel SPI DAC, then strobes LDAC once per burst
module dac_spi_driver
    import dac_spi_pkg::*;
#(
    parameter int   CLK_DIV  = 4,
    parameter logic DAC_BUF  = 1'b0,
    parameter logic DAC_GA_N = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] aout0,
    input  logic [11:0] aout1,
    input  logic        en,
    output logic        dac_cs_n,
    output logic        dac_sck,
    output logic        dac_mosi,
    output logic        dac_ldac_n,
    output logic        busy
);

    localparam int HW = $clog2(HALF_PERIODS);

    state_t                state, next_state;
    logic                  sel_ch, load_ch;
    logic [11:0]           sent0, sent1;
    logic                  force0, force1;
    logic                  pend0, pend1;
    logic [11:0]           load_data;
    logic [FRAME_BITS-1:0] frame, shreg;
    logic [HW-1:0]         half_cnt;
    logic                  run, tick, last_half;

    assign pend0     = force0 | (aout0 != sent0);
    assign pend1     = force1 | (aout1 != sent1);
    assign run       = (state == SHIFT) || (state == GAP) || (state == LATCH);
    assign busy      = (state != IDLE);
    assign last_half = (half_cnt == HW'(HALF_PERIODS - 1));
    assign load_data = sel_ch ? aout1 : aout0;

    always_comb begin
        frame                 = '0;
        frame[BIT_CH]         = sel_ch;
        frame[BIT_BUF]        = DAC_BUF;
        frame[BIT_GA_N]       = DAC_GA_N;
        frame[BIT_SHDN_N]     = 1'b1;
        frame[DATA_MSB:0]     = load_data;
    end

    spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load_ch    = sel_ch;
        case (state)
            IDLE: begin
                if (en && pend0) begin
                    next_state = LOAD;
                    load_ch    = 1'b0;
                end else if (en && pend1) begin
                    next_state = LOAD;
                    load_ch    = 1'b1;
                end
            end
            LOAD:  next_state = SHIFT;
            SHIFT: if (tick && last_half) next_state = GAP;
            GAP: begin
                // Only the channel not just sent may extend the burst; a re-pended
                // same channel waits for a fresh burst so LDAC latches the first value.
                if (tick) begin
                    if (en && (sel_ch ? pend0 : pend1)) begin
                        next_state = LOAD;
                        load_ch    = ~sel_ch;
                    end else begin
                        next_state = LATCH;
                    end
                end
            end
            LATCH:   if (tick) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_ch     <= 1'b0;
            sent0      <= '0;
            sent1      <= '0;
            force0     <= 1'b1;
            force1     <= 1'b1;
            shreg      <= '0;
            half_cnt   <= '0;
            dac_cs_n   <= 1'b1;
            dac_sck    <= 1'b0;
            dac_mosi   <= 1'b0;
            dac_ldac_n <= 1'b1;
        end else begin
            if (next_state == LOAD) sel_ch <= load_ch;
            case (state)
                LOAD: begin
                    shreg    <= frame;
                    half_cnt <= '0;
                    dac_cs_n <= 1'b0;
                    dac_sck  <= 1'b0;
                    dac_mosi <= frame[FRAME_BITS-1];
                    if (sel_ch) begin
                        sent1  <= aout1;
                        force1 <= 1'b0;
                    end else begin
                        sent0  <= aout0;
                        force0 <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        half_cnt <= half_cnt + HW'(1);
                        if (last_half) begin
                            dac_cs_n <= 1'b1;
                            dac_sck  <= 1'b0;
                            dac_mosi <= 1'b0;
                        end else begin
                            dac_sck <= ~dac_sck;
                            // Data moves only on the falling edge, giving a full half-period of setup.
                            if (dac_sck) begin
                                shreg    <= shreg << 1;
                                dac_mosi <= shreg[FRAME_BITS-2];
                            end
                        end
                    end
                end
                GAP:     if (tick && next_state == LATCH) dac_ldac_n <= 1'b0;
                LATCH:   if (tick) dac_ldac_n <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/dac_spi_driver.md
Name: dac_spi_driver

Overview:
- Downstream consumer of the instruction decoder's analog setpoints `aout0`/`aout1` (12-bit each).
- Serialises each setpoint change into a 16-bit SPI write to a dual-channel 12-bit DAC (MCP4922-style frame). The frame is write-only, SPI mode 0, MSB first.
- After all pending writes, pulses LDAC once so both DAC outputs update simultaneously.
- Holds every outbound SPI/LDAC pin at its idle level whenever no transfer is active.

Parameters:
- CLK_DIV, 4, SCK half-period in clk cycles; legal range ≥1. Divider counter width is clog2(CLK_DIV)+1.
- DAC_BUF, 0, value driven in frame bit 14 (VREF buffer).
- DAC_GA_N, 1, value driven in frame bit 13 (1 = gain 1x).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- aout0  in  12  channel A setpoint from decoder
- aout1  in  12  channel B setpoint from decoder
- en  in  1  1 = allow new frames to start
- dac_cs_n  out  1  SPI chip select, active low
- dac_sck  out  1  SPI clock
- dac_mosi  out  1  SPI data
- dac_ldac_n  out  1  DAC latch strobe, active low
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset is asynchronous and active-low; everything runs on the single clock `clk`.
- Reset values:
  - dac_cs_n=1, dac_sck=0, dac_mosi=0, dac_ldac_n=1, busy=0.
  - sent0=sent1=12'h000.
  - force0=force1=1, so both channels are written once after every reset.
- Pending flags (combinational):
  - pend0 = force0 | (aout0 != sent0)
  - pend1 = force1 | (aout1 != sent1)
- Frame word: {ch, DAC_BUF, DAC_GA_N, 1'b1 (SHDN_n), data[11:0]}, where ch=0 for aout0 and ch=1 for aout1.
- State machine: IDLE, LOAD, SHIFT, GAP, LATCH.
- IDLE:
  - If en=1 and pend0 → LOAD ch0.
  - Else if en=1 and pend1 → LOAD ch1.
  - Ch0 always wins when both are pending.
- LOAD (1 cycle):
  - Snapshot the selected aout into the shift register and into sentX; clear forceX.
  - Next cycle enters SHIFT with cs_n=0, sck=0, mosi=bit15.
- SHIFT:
  - Divider counts CLK_DIV cycles per half-period; sck toggles at each expiry.
  - mosi changes only on sck falling edges (and at SHIFT entry), giving the DAC setup of CLK_DIV cycles before each rising edge.
  - After 32 half-periods (16 rising edges), cs_n=1, sck=0, mosi=0 → GAP.
  - dac_cs_n stays low exactly 32*CLK_DIV cycles.
- GAP (CLK_DIV cycles, cs_n high):
  - If en=1 and the other channel is pending → LOAD that channel; otherwise → LATCH.
- LATCH: ldac_n=0 for CLK_DIV cycles, then ldac_n=1 → IDLE. Exactly one LDAC pulse per burst (one or two frames).
- Latency from an aout change (IDLE, en=1) to cs_n falling: 2 cycles (IDLE detect, LOAD).
- aout change mid-frame: the in-flight frame keeps its snapshot. Because sentX differs from the new value, the channel is re-pended.
  - Other channel: sent in the same burst.
  - Same channel: sent after LATCH, as a new burst.
- An aout that changes and returns to sentX before LOAD produces no frame.
- en=0 mid-burst: the current frame completes and LATCH still runs; no further LOAD occurs; pendings are retained.
- Reset mid-frame: pins return to idle levels immediately; the partial frame is discarded (the DAC ignores a CS rise before 16 clocks). Both channels are re-forced.

Decomposition:
- Package dac_spi_pkg holds:
  - state encoding (IDLE/LOAD/SHIFT/GAP/LATCH);
  - frame bit-position constants (CH=15, BUF=14, GA_N=13, SHDN_N=12, DATA=11:0);
  - FRAME_BITS=16.
- Sub-module spi_tick_gen: parameter CLK_DIV; inputs clk, rst_n, run; output tick, a 1-cycle pulse every CLK_DIV cycles while run=1.
  - Counter clears when run=0.
  - Reused for SHIFT, GAP and LATCH timing.

Test Plan:
- Reset release, en=1, CLK_DIV=2, aout0=aout1=0 → frame 16'h3000, then frame 16'hB000. Each has cs_n low 64 cycles, GAP 2 cycles, then one ldac_n low pulse of 2 cycles; busy falls after it.
- Idle, aout0←12'hABC → cs_n falls 2 cycles later. mosi sampled at the 16 sck rising edges = 16'h3ABC. ldac_n pulses once; no ch1 frame.
- aout0←12'h123 and aout1←12'h456 in the same cycle → frames 16'h3123 then 16'hB456, separated by GAP of CLK_DIV cycles, with a single LDAC pulse after the second frame.
- aout0←12'h111, then aout0←12'h222 during bit 8 of the frame → first frame carries 16'h3111 and completes with LDAC. A second burst then sends 16'h3222 with its own LDAC.
- rst_n asserted at sck rising edge 5 → cs_n=1, sck=0, mosi=0, ldac_n=1 in the same cycle (asynchronously). After release, both channels are re-sent with the current aout values.
- en=0, aout1←12'hFFF → no cs_n activity, busy=0. en←1 → frame 16'hBFFF followed by an LDAC pulse.
